// File: rtl/rf_scan_pkg.sv
`timescale 1ns/1ps
// Shared types for the register-file scan reader and its RF/display neighbours.
// Holds the scan FSM encoding and the default RF geometry.
package rf_scan_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } scan_state_e;

endpackage

// File: rtl/rf_scan_reader.sv
`timescale 1ns/1ps
// rf_scan_reader: walks FIRST_REG..LAST_REG over a spare RF read port, streams {addr,data} words.
// Latency: start to first out_valid 3 cycles, then one word per 3 cycles with out_ready high.
// Backpressure: the word stays frozen while out_ready=0; RF_SCAN_CHECKSUM_EN adds an XOR csum output.
module rf_scan_reader
    import rf_scan_pkg::*;
#(
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_qa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
`ifdef RF_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              accept;
    logic              start_ok;

    assign accept   = vld_q && out_ready;
    assign start_ok = (state_q == IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        vld_d   = vld_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        case (state_q)
            IDLE: begin
                // abort beats a simultaneous start: nothing begins, no done pulse
                if (start_ok) begin
                    state_d = ADDR;
                    ra_d    = FIRST_A;
                end
            end
            ADDR: begin
                state_d = abort ? DONE : CAPT;
            end
            CAPT: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    odata_d = rf_qa;
                    oaddr_d = ra_q;
                    vld_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    vld_d = 1'b0;
                    if (ra_q == LAST_A) begin
                        state_d = DONE;
                    end else begin
                        ra_d    = ra_q + ADDR_W'(1);
                        state_d = ADDR;
                    end
                end
                // a word handshaked alongside abort still counts as delivered
                if (abort) begin
                    vld_d   = 1'b0;
                    ra_d    = ra_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            ra_q    <= FIRST_A;
            vld_q   <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            vld_q   <= vld_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rf_ra     = ra_q;
    assign out_valid = vld_q;
    assign out_addr  = oaddr_q;
    assign out_data  = odata_q;

`ifdef RF_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if ((state_q == SEND) && accept) begin
            csum_q <= csum_q ^ odata_q;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_rf_scan_reader.sv
`timescale 1ns/1ps
// Bench for rf_scan_reader: full-range instance A and a 16..18 instance B share one modelled RF.
// Expected words come from an RF snapshot taken at start and the scan rules applied directly.
module tb_rf_scan_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] rf [32];

    logic          start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b0;
    logic          busy_a, done_a, vld_a;
    logic [AW-1:0] ra_a, addr_a;
    logic [DW-1:0] qa_a, data_a, csum_a;

    logic          start_b = 1'b0, abort_b = 1'b0, rdy_b = 1'b0;
    logic          busy_b, done_b, vld_b;
    logic [AW-1:0] ra_b, addr_b;
    logic [DW-1:0] qa_b, data_b, csum_b;

    assign qa_a = rf[ra_a];
    assign qa_b = rf[ra_b];

    rf_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clk(clk), .clr_n(clr_n), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .rf_ra(ra_a), .rf_qa(qa_a),
        .out_valid(vld_a), .out_ready(rdy_a), .out_addr(addr_a), .out_data(data_a)
`ifdef RF_SCAN_CHECKSUM_EN
        , .csum(csum_a)
`endif
    );

    rf_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_REG(16), .LAST_REG(18)) dut_b (
        .clk(clk), .clr_n(clr_n), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .rf_ra(ra_b), .rf_qa(qa_b),
        .out_valid(vld_b), .out_ready(rdy_b), .out_addr(addr_b), .out_data(data_b)
`ifdef RF_SCAN_CHECKSUM_EN
        , .csum(csum_b)
`endif
    );

`ifndef RF_SCAN_CHECKSUM_EN
    assign csum_a = '0;
    assign csum_b = '0;
`endif

    int errs = 0;
    int checks = 0;

    logic [DW-1:0] snap [32];
    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];
    int            done_cnt, done_cyc, first_vld;
    logic [DW-1:0] csum_at_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one scan on instance A; records every handshaked word and the done timing.
    task automatic scan_a(input int rdy_pct, input int stall_addr, input int abort_addr);
        bit stalled = 0;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0; done_cyc = -1; first_vld = -1;
        for (int i = 0; i < 32; i++) snap[i] = rf[i];
        @(negedge clk);
        start_a = 1'b1;
        rdy_a   = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            abort_a = 1'b0;
            if (vld_a && first_vld < 0) first_vld = cyc;
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
                csum_at_done = csum_a;
                chk("valid_low_in_done", {63'd0, vld_a}, 64'd0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("busy_after_done", {63'd0, busy_a}, 64'd0);
                break;
            end
            if (vld_a && stall_addr >= 0 && int'(addr_a) == stall_addr && !stalled) begin
                stalled = 1;
                rdy_a = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    cyc++;
                    if (k == 0) rf[stall_addr] = 32'hFF;
                    chk("stall_data_frozen", data_a, snap[stall_addr]);
                    chk("stall_addr_frozen", addr_a, stall_addr);
                    chk("stall_valid_held", {63'd0, vld_a}, 64'd1);
                end
                rdy_a = 1'b1;
            end else if (vld_a && abort_addr >= 0 && int'(addr_a) == abort_addr) begin
                abort_a = 1'b1;
                rdy_a   = 1'b0;
            end else begin
                rdy_a = (int'($urandom_range(99)) < rdy_pct);
            end
            if (vld_a && rdy_a) begin
                got_addr.push_back(addr_a);
                got_data.push_back(data_a);
            end
        end
        rdy_a = 1'b0;
        if (done_cyc < 0) chk("scan_timeout", 64'd1, 64'd0);
    endtask

    // Reference: one word per register first..last with the value held at start.
    task automatic check_words(input string tag, input int first, input int last);
        logic [DW-1:0] x = '0;
        chk({tag, "_count"}, got_addr.size(), last - first + 1);
        for (int a = first; a <= last; a++) begin
            int k = a - first;
            x = x ^ snap[a];
            if (k < got_addr.size()) begin
                chk({tag, "_addr"}, got_addr[k], a);
                chk({tag, "_data"}, got_data[k], snap[a]);
            end
        end
        chk({tag, "_done_pulses"}, done_cnt, 1);
`ifdef RF_SCAN_CHECKSUM_EN
        chk({tag, "_csum_at_done"}, csum_at_done, x);
        chk({tag, "_csum_after"}, csum_a, x);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        bit hit;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // reset values
        @(negedge clk);
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_done", {63'd0, done_a}, 64'd0);
        chk("rst_valid", {63'd0, vld_a}, 64'd0);
        chk("rst_ra_a", ra_a, 0);
        chk("rst_ra_b", ra_b, 16);
        chk("rst_out_addr", addr_a, 0);
        chk("rst_out_data", data_a, 0);
        clr_n = 1'b1;
        @(negedge clk);

        // full scan, sparse preload, ready held high
        rf[4] = 32'h04; rf[5] = 32'h05; rf[8] = 32'h08; rf[16] = 32'h10;
        scan_a(100, -1, -1);
        check_words("full", 0, 31);
        chk("first_valid_latency", first_vld, 3);
        chk("done_cycle", done_cyc, 97);
`ifdef RF_SCAN_CHECKSUM_EN
        chk("csum_preload", csum_at_done, 32'h19);
`endif

        // backpressure at addr 8 while the RF entry is overwritten
        scan_a(100, 8, -1);
        check_words("stall", 0, 31);

        // random contents, random ready
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        scan_a(50, -1, -1);
        check_words("random", 0, 31);

        // abort while offering addr 5
        scan_a(100, -1, 5);
        check_words("abort", 0, 4);
        chk("abort_done_cycle", done_cyc, 19);

        // start and abort together: nothing happens
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start_a = 1'b0; abort_a = 1'b0;
            if (done_a || busy_a) n_done++;
        end
        chk("start_abort_idle", n_done, 0);

        // asynchronous reset in the middle of a scan
        @(negedge clk);
        start_a = 1'b1; rdy_a = 1'b1;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (vld_a && addr_a == 5'd12) hit = 1;
        end
        chk("reached_addr12", {63'd0, hit}, 64'd1);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy_a}, 64'd0);
        chk("arst_valid", {63'd0, vld_a}, 64'd0);
        chk("arst_done", {63'd0, done_a}, 64'd0);
        chk("arst_ra", ra_a, 0);
        rdy_a = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        scan_a(70, -1, -1);
        check_words("after_reset", 0, 31);

        // narrow instance: three words, mid-scan start ignored
        rf[16] = 32'h10; rf[17] = 32'h11; rf[18] = 32'h12;
        for (int i = 0; i < 32; i++) snap[i] = rf[i];
        got_addr.delete(); got_data.delete();
        n_done = 0;
        @(negedge clk);
        start_b = 1'b1; rdy_b = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start_b = (c == 5);
            if (done_b) n_done++;
            if (vld_b && rdy_b) begin
                got_addr.push_back(addr_b);
                got_data.push_back(data_b);
            end
        end
        start_b = 1'b0;
        chk("narrow_count", got_addr.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_addr.size()) begin
                chk("narrow_addr", got_addr[k], 16 + k);
                chk("narrow_data", got_data[k], snap[16 + k]);
            end
        end
        chk("narrow_done_pulses", n_done, 1);
        chk("narrow_idle", {63'd0, busy_b}, 64'd0);
`ifdef RF_SCAN_CHECKSUM_EN
        chk("narrow_csum", csum_b, 32'h10 ^ 32'h11 ^ 32'h12);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rf_scan_reader.md
Name: rf_scan_reader

Overview:
- Read-side companion to the pipeline register file (RF) write port.
- Walks a configured register range through an RF read port (ra/qa) and emits one {address, data} word per register on a valid/ready stream.
- Feeds board display and debug dump logic, which then no longer needs hard-wired taps such as r8/r16/r17/r18.
- Sits beside the RF. It drives only a spare read-address port and never touches we/rw/rd.

Parameters:
- ADDR_W, 5: RF address width.
- DATA_W, 32: RF data width.
- FIRST_REG, 0: first register scanned.
- LAST_REG, 31: last register scanned. Must satisfy FIRST_REG <= LAST_REG <= 2^ADDR_W-1.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- clr_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin a scan; honoured only in IDLE.
- abort, input, 1: terminate the current scan.
- busy, output, 1: high from the cycle after an accepted start until return to IDLE.
- done, output, 1: one-cycle pulse when the scan completes or is aborted.
- rf_ra, output, ADDR_W: RF read address; drive to the RF qa-side port.
- rf_qa, input, DATA_W: RF combinational read data for rf_ra.
- out_valid, output, 1: stream word available.
- out_ready, input, 1: consumer accepts the word.
- out_addr, output, ADDR_W: register index of the current word.
- out_data, output, DATA_W: captured register value.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE; busy=0, done=0, out_valid=0; rf_ra=FIRST_REG; out_addr=0; out_data=0.
- IDLE:
  - start=1 -> ADDR; rf_ra<=FIRST_REG.
  - start and abort in the same cycle: abort wins; stay IDLE, no done pulse.
- ADDR (one cycle): rf_ra is stable and the RF read settles. Go to CAPT.
- CAPT (one cycle): out_data<=rf_qa, out_addr<=rf_ra, out_valid<=1. Go to SEND.
- SEND:
  - out_data/out_addr stay frozen while out_valid=1 && out_ready=0, even if the RF is written meanwhile.
  - On out_valid && out_ready:
    - if rf_ra==LAST_REG: out_valid<=0, go to DONE.
    - otherwise: rf_ra<=rf_ra+1, out_valid<=0, go to ADDR.
- DONE (one cycle): done=1, busy=0 next. Go to IDLE.
- Latency:
  - start to first out_valid: 3 cycles (start edge, ADDR, CAPT).
  - Register-to-register throughput with out_ready held high: one word per 3 cycles.
  - A full 32-register scan with out_ready=1 takes 96 cycles plus the DONE cycle.
- abort=1 in ADDR, CAPT or SEND: out_valid<=0 next cycle, go to DONE. No further word is emitted.
  - A word handshaked in the same cycle as abort counts as delivered.
- start while busy: ignored.
- FIRST_REG==LAST_REG: exactly one word, then DONE.
- The address counter never wraps; the scan stops at LAST_REG.
- Register 0 is emitted with whatever the RF returns (0 for a compliant RF).
- Reading a register written in the same cycle: the value captured is whatever rf_qa shows at the CAPT edge. No forwarding is performed.

Optional Feature:
- Macro: RF_SCAN_CHECKSUM_EN.
- Defined:
  - Adds output csum [DATA_W-1:0].
  - csum is cleared to 0 on accepted start and on reset.
  - csum <= csum XOR out_data on every accepted word.
  - The final value is stable from the DONE cycle until the next accepted start.
  - On abort, csum covers only the words delivered.
- Not defined: port absent; no accumulator logic.

Decomposition:
- Shared package rf_scan_pkg holds:
  - state enum {IDLE, ADDR, CAPT, SEND, DONE} in 3 bits;
  - localparams RF_ADDR_W=5 and RF_DATA_W=32, for reuse by the RF and display logic.
- No sub-module is needed: one FSM, one address counter and one capture register.

Test Plan:
- Preload R4=04H, R5=05H, R8=08H, R16=10H via the RF write port; start with out_ready=1 -> 32 words in order, addr 0..31; words 4/5/8/16 carry 04H/05H/08H/10H, all others 0; one done pulse ~97 cycles after start.
- Hold out_ready=0 for 10 cycles at addr 8 while writing R8=FFH -> out_data stays 08H throughout; after ready the next word is addr 9.
- Parameters FIRST_REG=16, LAST_REG=18 with R16=10H, R17=11H, R18=12H -> exactly three words 10H/11H/12H, then done; a start pulsed mid-scan is ignored.
- abort asserted while in SEND at addr 5 -> no word for addr 5 and above after handshake; done pulses; busy=0 the next cycle.
- clr_n low mid-scan at addr 12 -> busy/out_valid/done drop immediately (asynchronously); a fresh start then restarts at addr FIRST_REG.
- With RF_SCAN_CHECKSUM_EN and the first scenario's preload -> csum = 04H^05H^08H^10H = 19H at done.
